// File: rtl/l2_tlb_miss_ctrl_pkg.sv
// l2_tlb_miss_ctrl_pkg
// Shared definitions for the L2 TLB miss controller:
//   - FSM state encoding
//   - PROT_R/W/X bit positions inside the 3-bit {x,w,r} permission field
//   - PMA region table (base, limit, permission) and a range helper
package l2_tlb_miss_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    PTW_REQ  = 3'd2,
    PTW_WAIT = 3'd3,
    RESP     = 3'd4
  } state_t;

  localparam int PROT_R = 0;
  localparam int PROT_W = 1;
  localparam int PROT_X = 2;

  localparam logic [2:0] PROT_RWX = 3'b111;
  localparam logic [2:0] PROT_RX  = 3'((1 << PROT_X) | (1 << PROT_R));
  localparam logic [2:0] PROT_RW  = 3'((1 << PROT_W) | (1 << PROT_R));

  // Region i covers [PMA_BASE[i], PMA_LIMIT[i]); regions are disjoint.
  localparam int PMA_REGIONS = 5;
  localparam logic [PMA_REGIONS-1:0][31:0] PMA_BASE = {
    32'h8000_0000, 32'h0C00_0000, 32'h0200_0000, 32'h0000_1000, 32'h0000_0000
  };
  localparam logic [PMA_REGIONS-1:0][31:0] PMA_LIMIT = {
    32'h9000_0000, 32'h1000_0000, 32'h0201_0000, 32'h0000_2000, 32'h0000_1000
  };
  localparam logic [PMA_REGIONS-1:0][2:0] PMA_PROT = {
    PROT_RWX, PROT_RW, PROT_RW, PROT_RX, PROT_RWX
  };

  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] limit);
    return (addr >= base) && (addr < limit);
  endfunction

endpackage

// File: rtl/l2_tlb_miss_ctrl_if.sv
// l2_tlb_miss_ctrl_if
// Bundles the ITLB/DTLB miss request ports, the response port, the PTW
// request/response ports and sfence.
//   slave  : controller side (takes requests, drives responses and PTW requests)
//   master : environment side (L1 TLBs + PTW)
interface l2_tlb_miss_ctrl_if #(
  parameter int VPN_W = 20,
  parameter int PPN_W = 20
);
  logic             io_itlb_req_valid;
  logic             io_itlb_req_ready;
  logic [VPN_W-1:0] io_itlb_req_bits_vpn;
  logic             io_dtlb_req_valid;
  logic             io_dtlb_req_ready;
  logic [VPN_W-1:0] io_dtlb_req_bits_vpn;
  logic             io_resp_valid;
  logic             io_resp_bits_id;
  logic [PPN_W-1:0] io_resp_bits_ppn;
  logic [2:0]       io_resp_bits_prot;
  logic             io_resp_bits_hit;
  logic             io_ptw_req_valid;
  logic             io_ptw_req_ready;
  logic [VPN_W-1:0] io_ptw_req_bits_vpn;
  logic             io_ptw_resp_valid;
  logic [PPN_W-1:0] io_ptw_resp_bits_pte_ppn;
  logic             io_sfence_valid;

  modport slave (
    input  io_itlb_req_valid, io_itlb_req_bits_vpn,
    input  io_dtlb_req_valid, io_dtlb_req_bits_vpn,
    output io_itlb_req_ready, io_dtlb_req_ready,
    output io_resp_valid, io_resp_bits_id, io_resp_bits_ppn,
    output io_resp_bits_prot, io_resp_bits_hit,
    output io_ptw_req_valid, io_ptw_req_bits_vpn,
    input  io_ptw_req_ready, io_ptw_resp_valid, io_ptw_resp_bits_pte_ppn,
    input  io_sfence_valid
  );

  modport master (
    output io_itlb_req_valid, io_itlb_req_bits_vpn,
    output io_dtlb_req_valid, io_dtlb_req_bits_vpn,
    input  io_itlb_req_ready, io_dtlb_req_ready,
    input  io_resp_valid, io_resp_bits_id, io_resp_bits_ppn,
    input  io_resp_bits_prot, io_resp_bits_hit,
    input  io_ptw_req_valid, io_ptw_req_bits_vpn,
    output io_ptw_req_ready, io_ptw_resp_valid, io_ptw_resp_bits_pte_ppn,
    output io_sfence_valid
  );
endinterface

// File: rtl/l2_tlb_pma_check.sv
// l2_tlb_pma_check
// Combinational PMA lookup: page number -> {x,w,r} permissions.
//   ppn  in  PPN_W  physical page number (byte address = ppn << 12, 32-bit)
//   prot out 3      OR of the permissions of every matching region, 0 if none
module l2_tlb_pma_check
  import l2_tlb_miss_ctrl_pkg::*;
#(
  parameter int PPN_W = 20
) (
  input  logic [PPN_W-1:0] ppn,
  output logic [2:0]       prot
);
  logic [31:0] addr;

  always_comb begin
    addr = 32'(ppn) << 12;
    prot = '0;
    for (int i = 0; i < PMA_REGIONS; i++) begin
      if (in_range(addr, PMA_BASE[i], PMA_LIMIT[i])) prot |= PMA_PROT[i];
    end
  end
endmodule

// File: rtl/l2_tlb_miss_ctrl.sv
// l2_tlb_miss_ctrl
// Shared L2 TLB between the ITLB and DTLB miss ports and the page-table
// walker. Round-robin arbitration, one request in flight, fully associative
// ENTRIES-deep array with a wrapping replacement pointer, one-cycle response.
//   clk, reset : clock, synchronous active-high reset
//   io         : l2_tlb_miss_ctrl_if.slave (requests, response, PTW, sfence)
// Build option: L2TLB_PMA_CHECK_EN -- when defined, fill permissions come
// from the PMA map (l2_tlb_pma_check); otherwise every fill gets RWX.
module l2_tlb_miss_ctrl
  import l2_tlb_miss_ctrl_pkg::*;
#(
  parameter int VPN_W   = 20,
  parameter int PPN_W   = 20,
  parameter int ENTRIES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  l2_tlb_miss_ctrl_if.slave     io
);
  localparam int IDX_W = $clog2(ENTRIES);

  state_t state, state_nxt;

  logic             last_dtlb;   // 1 = previous grant went to DTLB
  logic             gnt_i, gnt_d, accept, fill;
  logic [VPN_W-1:0] vpn_q;
  logic             id_q;
  logic [PPN_W-1:0] ppn_q;
  logic [2:0]       prot_q;
  logic             hit_q;

  logic [ENTRIES-1:0]            ent_vld;
  logic [ENTRIES-1:0][VPN_W-1:0] ent_vpn;
  logic [ENTRIES-1:0][PPN_W-1:0] ent_ppn;
  logic [ENTRIES-1:0][2:0]       ent_prot;
  logic [IDX_W-1:0]              repl_ptr;

  logic [ENTRIES-1:0] hit_vec;
  logic               lookup_hit;
  logic [PPN_W-1:0]   hit_ppn;
  logic [2:0]         hit_prot;
  logic [2:0]         fill_prot;

  // Ready is a pure function of the valids while IDLE; on contention the
  // requester not served last wins.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (state == IDLE) begin
      gnt_i = io.io_itlb_req_valid && (!io.io_dtlb_req_valid ||  last_dtlb);
      gnt_d = io.io_dtlb_req_valid && (!io.io_itlb_req_valid || !last_dtlb);
    end
  end

  assign accept = gnt_i | gnt_d;
  assign fill   = (state == PTW_WAIT) && io.io_ptw_resp_valid;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
    assign hit_vec[g] = ent_vld[g] && (ent_vpn[g] == vpn_q);
  end

  // Tags are never duplicated, so hit_vec is one-hot or zero and an OR
  // mux selects the matching entry.
  always_comb begin
    hit_ppn  = '0;
    hit_prot = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (hit_vec[i]) begin
        hit_ppn  |= ent_ppn[i];
        hit_prot |= ent_prot[i];
      end
    end
  end
  assign lookup_hit = |hit_vec;

`ifdef L2TLB_PMA_CHECK_EN
  l2_tlb_pma_check #(.PPN_W(PPN_W)) u_pma (
    .ppn  (io.io_ptw_resp_bits_pte_ppn),
    .prot (fill_prot)
  );
`else
  assign fill_prot = PROT_RWX;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (accept) state_nxt = LOOKUP;
      LOOKUP:   state_nxt = lookup_hit ? RESP : PTW_REQ;
      PTW_REQ:  if (io.io_ptw_req_ready) state_nxt = PTW_WAIT;
      PTW_WAIT: if (io.io_ptw_resp_valid) state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_dtlb <= 1'b1;
      vpn_q     <= '0;
      id_q      <= 1'b0;
      ppn_q     <= '0;
      prot_q    <= '0;
      hit_q     <= 1'b0;
      ent_vld   <= '0;
      repl_ptr  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        vpn_q     <= gnt_d ? io.io_dtlb_req_bits_vpn : io.io_itlb_req_bits_vpn;
        id_q      <= gnt_d;
        last_dtlb <= gnt_d;
      end
      if (state == LOOKUP && lookup_hit) begin
        ppn_q  <= hit_ppn;
        prot_q <= hit_prot;
        hit_q  <= 1'b1;
      end
      if (fill) begin
        ppn_q    <= io.io_ptw_resp_bits_pte_ppn;
        prot_q   <= fill_prot;
        hit_q    <= 1'b0;
        repl_ptr <= repl_ptr + 1'b1;
        if (!io.io_sfence_valid) ent_vld[repl_ptr] <= 1'b1;
      end
      // Flush wins over a same-cycle fill.
      if (io.io_sfence_valid) ent_vld <= '0;
    end
  end

  // Entry payload needs no reset: it is qualified by ent_vld.
  always_ff @(posedge clk) begin
    if (fill && !io.io_sfence_valid) begin
      ent_vpn[repl_ptr]  <= vpn_q;
      ent_ppn[repl_ptr]  <= io.io_ptw_resp_bits_pte_ppn;
      ent_prot[repl_ptr] <= fill_prot;
    end
  end

  assign io.io_itlb_req_ready   = gnt_i;
  assign io.io_dtlb_req_ready   = gnt_d;
  assign io.io_resp_valid       = (state == RESP);
  assign io.io_resp_bits_id     = id_q;
  assign io.io_resp_bits_ppn    = ppn_q;
  assign io.io_resp_bits_prot   = prot_q;
  assign io.io_resp_bits_hit    = hit_q;
  assign io.io_ptw_req_valid    = (state == PTW_REQ);
  assign io.io_ptw_req_bits_vpn = vpn_q;

endmodule

// File: tb/tb_l2_tlb_miss_ctrl.sv
// tb_l2_tlb_miss_ctrl
// Self-checking bench for l2_tlb_miss_ctrl. A behavioural model (entry
// array + round-robin flag + PMA address ranges) predicts each response.
// Honors L2TLB_PMA_CHECK_EN the same way the design does.
module tb_l2_tlb_miss_ctrl;
  localparam int VPN_W = 20, PPN_W = 20, ENTRIES = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l2_tlb_miss_ctrl_if #(.VPN_W(VPN_W), .PPN_W(PPN_W)) bus();

  l2_tlb_miss_ctrl #(.VPN_W(VPN_W), .PPN_W(PPN_W), .ENTRIES(ENTRIES)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  typedef struct {
    bit          to;
    bit          gi, gd;
    bit          walked;
    logic [19:0] ptw_vpn;
    bit          id;
    logic [19:0] ppn;
    logic [2:0]  prot;
    bit          hit;
    int          lat;
  } obs_t;

  typedef struct {
    bit          id;
    logic [19:0] vpn;
    logic [19:0] ppn;
    logic [2:0]  prot;
    bit          hit;
    int          lat;
  } exp_t;

  // ---------------- reference model ----------------
  bit          m_vld [ENTRIES];
  logic [19:0] m_vpn [ENTRIES];
  logic [19:0] m_ppn [ENTRIES];
  logic [2:0]  m_prt [ENTRIES];
  int          m_ptr;
  bit          m_last;   // 1 = DTLB served last

  function automatic logic [2:0] m_prot(input logic [19:0] ppn);
`ifdef L2TLB_PMA_CHECK_EN
    logic [31:0] a;
    a = {ppn, 12'h000};
    if (a < 32'h0000_1000) return 3'd7;
    if (a >= 32'h0000_1000 && a < 32'h0000_2000) return 3'd5;
    if (a >= 32'h0200_0000 && a < 32'h0201_0000) return 3'd3;
    if (a >= 32'h0C00_0000 && a < 32'h1000_0000) return 3'd3;
    if (a >= 32'h8000_0000 && a < 32'h9000_0000) return 3'd7;
    return 3'd0;
`else
    return (ppn == ppn) ? 3'd7 : 3'd7;
`endif
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) m_vld[i] = 0;
    m_ptr  = 0;
    m_last = 1;
  endtask

  task automatic model_txn(input bit vi, input bit vd, input logic [19:0] vpn_i,
                           input logic [19:0] vpn_d, input logic [19:0] wppn,
                           input bit sf, output exp_t e);
    int idx;
    e.id   = (vi && vd) ? !m_last : vd;
    m_last = e.id;
    e.vpn  = e.id ? vpn_d : vpn_i;
    idx = -1;
    for (int i = 0; i < ENTRIES; i++) if (m_vld[i] && m_vpn[i] == e.vpn) idx = i;
    if (idx >= 0) begin
      e.ppn = m_ppn[idx]; e.prot = m_prt[idx]; e.hit = 1; e.lat = 2;
    end else begin
      e.ppn = wppn; e.prot = m_prot(wppn); e.hit = 0; e.lat = 4;
      if (sf) begin
        for (int i = 0; i < ENTRIES; i++) m_vld[i] = 0;
      end else begin
        m_vld[m_ptr] = 1; m_vpn[m_ptr] = e.vpn; m_ppn[m_ptr] = wppn; m_prt[m_ptr] = e.prot;
      end
      m_ptr = (m_ptr + 1) % ENTRIES;
    end
  endtask

  // ---------------- stimulus driver ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1;
    bus.io_itlb_req_valid = 0; bus.io_dtlb_req_valid = 0;
    bus.io_ptw_resp_valid = 0; bus.io_sfence_valid = 0; bus.io_ptw_req_ready = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    m_reset();
  endtask

  // Presents a request, answers the PTW (with sfence on the fill cycle if
  // sf), and records what the DUT returned and how long it took.
  task automatic transact(input bit vi, input bit vd, input logic [19:0] vpn_i,
                          input logic [19:0] vpn_d, input logic [19:0] wppn,
                          input bit sf, output obs_t o);
    int hs;
    bit done;
    o = '{default: 0};
    hs = 0;
    @(posedge clk); #1;
    bus.io_itlb_req_valid = vi; bus.io_itlb_req_bits_vpn = vpn_i;
    bus.io_dtlb_req_valid = vd; bus.io_dtlb_req_bits_vpn = vpn_d;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.io_itlb_req_ready || bus.io_dtlb_req_ready) begin
        o.gi = bus.io_itlb_req_ready; o.gd = bus.io_dtlb_req_ready;
        hs = cyc; done = 1;
      end
    end
    @(posedge clk); #1;
    bus.io_itlb_req_valid = 0; bus.io_dtlb_req_valid = 0;
    if (!done) o.to = 1;
    else begin
      done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        if (bus.io_resp_valid) begin
          o.id = bus.io_resp_bits_id; o.ppn = bus.io_resp_bits_ppn;
          o.prot = bus.io_resp_bits_prot; o.hit = bus.io_resp_bits_hit;
          o.lat = cyc - hs; done = 1;
        end else if (bus.io_ptw_req_valid && bus.io_ptw_req_ready) begin
          o.walked = 1; o.ptw_vpn = bus.io_ptw_req_bits_vpn;
          @(posedge clk); #1;
          bus.io_ptw_resp_valid = 1; bus.io_ptw_resp_bits_pte_ppn = wppn;
          bus.io_sfence_valid = sf;
          @(posedge clk); #1;
          bus.io_ptw_resp_valid = 0; bus.io_sfence_valid = 0;
        end
      end
      if (!done) o.to = 1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_chk++;
    if ({bus.io_itlb_req_ready, bus.io_dtlb_req_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b want 00", {bus.io_itlb_req_ready, bus.io_dtlb_req_ready});
    end
    n_chk++;
    if ({bus.io_resp_valid, bus.io_resp_bits_id, bus.io_resp_bits_ppn, bus.io_resp_bits_prot, bus.io_resp_bits_hit} !== '0) begin
      n_fail++; $display("FAIL reset_resp: got valid=%b ppn=%h want all 0", bus.io_resp_valid, bus.io_resp_bits_ppn);
    end
    n_chk++;
    if ({bus.io_ptw_req_valid, bus.io_ptw_req_bits_vpn} !== '0) begin
      n_fail++; $display("FAIL reset_ptw: got valid=%b vpn=%h want 0", bus.io_ptw_req_valid, bus.io_ptw_req_bits_vpn);
    end
  endtask

  task automatic test_miss_then_hit();
    obs_t o; exp_t e;
    for (int k = 0; k < 2; k++) begin
      transact(1, 0, 20'h00080, 20'h0, 20'h80000, 0, o);
      model_txn(1, 0, 20'h00080, 20'h0, 20'h80000, 0, e);
      n_chk++;
      if (o.to || o.id !== e.id || o.ppn !== e.ppn || o.prot !== e.prot || o.hit !== e.hit ||
          o.walked !== !e.hit || (o.walked && o.ptw_vpn !== e.vpn)) begin
        n_fail++; $display("FAIL miss_hit[%0d]: got id=%0d ppn=%h prot=%0d hit=%0d walk=%0d to=%0d want id=%0d ppn=%h prot=%0d hit=%0d",
                           k, o.id, o.ppn, o.prot, o.hit, o.walked, o.to, e.id, e.ppn, e.prot, e.hit);
      end
      n_chk++;
      if (o.lat !== e.lat) begin
        n_fail++; $display("FAIL miss_hit_latency[%0d]: got %0d want %0d", k, o.lat, e.lat);
      end
    end
  endtask

  task automatic test_arbitration();
    obs_t o; exp_t e;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      transact(1, 1, 20'h00100 + 20'(k), 20'h00200 + 20'(k), 20'h00400 + 20'(k), 0, o);
      model_txn(1, 1, 20'h00100 + 20'(k), 20'h00200 + 20'(k), 20'h00400 + 20'(k), 0, e);
      n_chk++;
      if ({o.gi, o.gd} !== (e.id ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL arb_grant[%0d]: got ready i/d=%b%b want id %0d only", k, o.gi, o.gd, e.id);
      end
      n_chk++;
      if (o.to || o.id !== e.id || o.ppn !== e.ppn || o.hit !== e.hit) begin
        n_fail++; $display("FAIL arb_resp[%0d]: got id=%0d ppn=%h hit=%0d to=%0d want id=%0d ppn=%h hit=%0d",
                           k, o.id, o.ppn, o.hit, o.to, e.id, e.ppn, e.hit);
      end
    end
  endtask

  task automatic test_pma();
    obs_t o; exp_t e;
    logic [19:0] tbl [6];
    tbl[0] = 20'h00001; tbl[1] = 20'h02000; tbl[2] = 20'h0C000;
    tbl[3] = 20'h12345; tbl[4] = 20'h80000; tbl[5] = 20'h00000;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      transact(0, 1, 20'h0, 20'h00700 + 20'(k), tbl[k], 0, o);
      model_txn(0, 1, 20'h0, 20'h00700 + 20'(k), tbl[k], 0, e);
      n_chk++;
      if (o.to || o.prot !== e.prot || o.ppn !== e.ppn || o.id !== e.id) begin
        n_fail++; $display("FAIL pma[%h]: got prot=%0d ppn=%h id=%0d to=%0d want prot=%0d ppn=%h id=%0d",
                           tbl[k], o.prot, o.ppn, o.id, o.to, e.prot, e.ppn, e.id);
      end
    end
  endtask

  task automatic test_replacement();
    obs_t o; exp_t e;
    logic [19:0] v;
    do_reset();
    for (int k = 0; k < 11; k++) begin
      // 9 distinct fills, then the second vpn (still resident), then the first (evicted)
      v = (k < 9) ? 20'h00500 + 20'(k) : (k == 9 ? 20'h00501 : 20'h00500);
      transact(1, 0, v, 20'h0, 20'h00900 + 20'(k), 0, o);
      model_txn(1, 0, v, 20'h0, 20'h00900 + 20'(k), 0, e);
      n_chk++;
      if (o.to || o.hit !== e.hit || o.ppn !== e.ppn || o.walked !== !e.hit) begin
        n_fail++; $display("FAIL repl[%0d] vpn=%h: got hit=%0d ppn=%h walk=%0d to=%0d want hit=%0d ppn=%h",
                           k, v, o.hit, o.ppn, o.walked, o.to, e.hit, e.ppn);
      end
    end
  endtask

  task automatic test_sfence_fill();
    obs_t o; exp_t e;
    logic [19:0] vl [6];
    bit          sl [6];
    vl[0] = 20'h00600; vl[1] = 20'h00601; vl[2] = 20'h00602;
    vl[3] = 20'h00602; vl[4] = 20'h00600; vl[5] = 20'h00601;
    sl = '{0, 0, 1, 0, 0, 0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      transact(1, 0, vl[k], 20'h0, 20'h00a00 + 20'(k), sl[k], o);
      model_txn(1, 0, vl[k], 20'h0, 20'h00a00 + 20'(k), sl[k], e);
      n_chk++;
      if (o.to || o.hit !== e.hit || o.ppn !== e.ppn || o.prot !== e.prot || o.walked !== !e.hit) begin
        n_fail++; $display("FAIL sfence[%0d] vpn=%h: got hit=%0d ppn=%h prot=%0d to=%0d want hit=%0d ppn=%h prot=%0d",
                           k, vl[k], o.hit, o.ppn, o.prot, o.to, e.hit, e.ppn, e.prot);
      end
    end
  endtask

  task automatic test_ptw_stall_reset();
    obs_t o; exp_t e;
    bit seen, bad;
    do_reset();
    bus.io_ptw_req_ready = 0;
    @(posedge clk); #1;
    bus.io_itlb_req_valid = 1; bus.io_itlb_req_bits_vpn = 20'h0abcd;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = bus.io_itlb_req_ready; end
    @(posedge clk); #1;
    bus.io_itlb_req_valid = 0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = bus.io_ptw_req_valid; end
    n_chk++;
    if (!seen) begin n_fail++; $display("FAIL stall_req_seen: got no ptw_req_valid want 1"); end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      n_chk++;
      if (bus.io_ptw_req_valid !== 1'b1 || bus.io_ptw_req_bits_vpn !== 20'h0abcd) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got valid=%b vpn=%h want 1/0abcd", c, bus.io_ptw_req_valid, bus.io_ptw_req_bits_vpn);
      end
    end
    @(posedge clk); #1 bus.io_ptw_req_ready = 1;
    @(posedge clk); #1;              // now waiting for the walk
    reset = 1; bus.io_ptw_resp_valid = 1; bus.io_ptw_resp_bits_pte_ppn = 20'h11111;
    @(posedge clk); #1 reset = 0;
    m_reset();
    @(negedge clk);
    n_chk++;
    if ({bus.io_itlb_req_ready, bus.io_dtlb_req_ready, bus.io_resp_valid, bus.io_resp_bits_id, bus.io_resp_bits_ppn,
         bus.io_resp_bits_prot, bus.io_resp_bits_hit, bus.io_ptw_req_valid, bus.io_ptw_req_bits_vpn} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got resp_v=%b ppn=%h ptw_v=%b vpn=%h want all 0",
                         bus.io_resp_valid, bus.io_resp_bits_ppn, bus.io_ptw_req_valid, bus.io_ptw_req_bits_vpn);
    end
    @(posedge clk); #1 bus.io_ptw_resp_valid = 0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (bus.io_resp_valid !== 1'b0) bad = 1; end
    n_chk++;
    if (bad) begin n_fail++; $display("FAIL midreset_no_resp: got resp_valid=1 want 0"); end
    transact(1, 0, 20'h0abcd, 20'h0, 20'h22222, 0, o);
    model_txn(1, 0, 20'h0abcd, 20'h0, 20'h22222, 0, e);
    n_chk++;
    if (o.to || o.hit !== e.hit || o.ppn !== e.ppn || o.walked !== !e.hit) begin
      n_fail++; $display("FAIL after_reset: got hit=%0d ppn=%h to=%0d want hit=%0d ppn=%h", o.hit, o.ppn, o.to, e.hit, e.ppn);
    end
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    logic [19:0] tbl [6];
    logic [19:0] vi_v, vd_v, wp;
    int sel;
    bit sf;
    tbl[0] = 20'h00000; tbl[1] = 20'h00001; tbl[2] = 20'h02005;
    tbl[3] = 20'h0C123; tbl[4] = 20'h80abc;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      tbl[5] = 20'($urandom);
      sel  = $urandom_range(1, 3);
      vi_v = 20'h03000 + 20'($urandom_range(0, 11));
      vd_v = 20'h03000 + 20'($urandom_range(0, 11));
      wp   = tbl[$urandom_range(0, 5)];
      sf   = ($urandom_range(0, 7) == 0);
      transact(sel[0], sel[1], vi_v, vd_v, wp, sf, o);
      model_txn(sel[0], sel[1], vi_v, vd_v, wp, sf, e);
      n_chk++;
      if (o.to || o.id !== e.id || o.ppn !== e.ppn || o.prot !== e.prot || o.hit !== e.hit ||
          o.walked !== !e.hit || (o.walked && o.ptw_vpn !== e.vpn) || o.lat !== e.lat) begin
        n_fail++; $display("FAIL rand[%0d]: got id=%0d ppn=%h prot=%0d hit=%0d lat=%0d to=%0d want id=%0d ppn=%h prot=%0d hit=%0d lat=%0d",
                           k, o.id, o.ppn, o.prot, o.hit, o.lat, o.to, e.id, e.ppn, e.prot, e.hit, e.lat);
      end
    end
  endtask

  initial begin
    bus.io_itlb_req_valid = 0; bus.io_itlb_req_bits_vpn = '0;
    bus.io_dtlb_req_valid = 0; bus.io_dtlb_req_bits_vpn = '0;
    bus.io_ptw_req_ready = 1; bus.io_ptw_resp_valid = 0;
    bus.io_ptw_resp_bits_pte_ppn = '0; bus.io_sfence_valid = 0;
    m_reset();
    test_reset();
    test_miss_then_hit();
    test_arbitration();
    test_pma();
    test_replacement();
    test_sfence_fill();
    test_ptw_stall_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
